competition_scheduler: RTL and testbench

- Sequences competition mode (mode 3'b010): walks each player through every question in turn.
- Per question it runs a read countdown, then an answer countdown.
- Opens the answer window on the answer checker with a start pulse and collects its valid/correct result.
- Keeps per-player scores.
- Sits between the debounced button/edge logic and the answer checker/display path, and owns the question index, player index and timer.

---
 rtl/competition_pkg.sv | 26 ++
 rtl/competition_scheduler_sec_tick_gen.sv | 41 ++++
 rtl/competition_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_competition_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/competition_pkg.sv
// Shared definitions for the competition-mode scheduler.
// Holds the board mode code that enables the block, the FSM state encoding
// (which is also exported on the state output), the score width, default
// phase lengths and a saturating increment helper for scores.
package competition_pkg;

    localparam logic [2:0] MODE_COMPETE   = 3'b010;
    localparam int         SCORE_W        = 6;
    localparam int         READ_SEC_DEF   = 4;
    localparam int         ANSWER_SEC_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_ANSWER  = 3'd2,
        ST_RESULT  = 3'd3,
        ST_ADVANCE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // Scores stick at their maximum rather than wrapping back to zero.
    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/competition_scheduler_sec_tick_gen.sv
// One-second tick generator.
// Ports:
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   clr_i   - synchronous clear; restarts the current second from zero
//   tick_o  - high for one cycle when the counter reaches CLK_FREQ-1
module sec_tick_gen #(
    parameter int CLK_FREQ = 50000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int              CNT_W   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_FREQ - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The tick is decoded from the registered count only, so it never
    // depends on clr_i; this keeps the FSM -> clear -> tick path loop-free.
    assign tick_o = (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clr_i || (cnt_q == CNT_MAX)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/competition_scheduler.sv
// Competition-mode scheduler: walks every player through every question,
// running a read countdown then an answer countdown per question, opening
// the answer checker's window and keeping per-player scores.
// Ports:
//   clk_i, rst_ni              - clock, asynchronous active-low reset
//   mode_i                     - board mode; block runs only in MODE_COMPETE
//   total_i, num_players_i     - round size, captured when a round starts
//   start_pulse_i              - start/confirm (from IDLE or DONE)
//   submit_pulse_i             - advance out of RESULT
//   ans_valid_i, ans_correct_i - checker result
//   chk_start_o                - one-cycle pulse on ANSWER entry
//   answer_open_o              - high throughout ANSWER
//   q_idx_o, player_idx_o      - current question / player
//   state_o                    - encoded FSM state
//   time_left_o                - seconds left in the current phase
//   last_correct_o, last_timeout_o, last_elapsed_o - last closed question
//   scores_flat_o              - {score[MAX_P-1], ..., score[0]}
//   round_done_o               - high in DONE
module competition_scheduler
    import competition_pkg::*;
#(
    parameter int  CLK_FREQ   = 50000000,
    parameter int  READ_SEC   = READ_SEC_DEF,
    parameter int  ANSWER_SEC = ANSWER_SEC_DEF,
    parameter int  MAX_P      = 4,
    localparam int PIDX_W     = (MAX_P > 1) ? $clog2(MAX_P) : 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [2:0]                 mode_i,
    input  logic [5:0]                 total_i,
    input  logic [2:0]                 num_players_i,
    input  logic                       start_pulse_i,
    input  logic                       submit_pulse_i,
    input  logic                       ans_valid_i,
    input  logic                       ans_correct_i,
    output logic                       chk_start_o,
    output logic                       answer_open_o,
    output logic [5:0]                 q_idx_o,
    output logic [PIDX_W-1:0]          player_idx_o,
    output logic [2:0]                 state_o,
    output logic [4:0]                 time_left_o,
    output logic                       last_correct_o,
    output logic                       last_timeout_o,
    output logic [4:0]                 last_elapsed_o,
    output logic [MAX_P*SCORE_W-1:0]   scores_flat_o,
    output logic                       round_done_o
);

    localparam logic [4:0] READ_TIME   = 5'(READ_SEC);
    localparam logic [4:0] ANSWER_TIME = 5'(ANSWER_SEC);

    state_e                        state_q,         state_d;
    logic [5:0]                    qIdx_q,          qIdx_d;
    logic [PIDX_W-1:0]             playerIdx_q,     playerIdx_d;
    logic [4:0]                    timeLeft_q,      timeLeft_d;
    logic [MAX_P-1:0][SCORE_W-1:0] scores_q,        scores_d;
    logic                          lastCorrect_q,   lastCorrect_d;
    logic                          lastTimeout_q,   lastTimeout_d;
    logic [4:0]                    lastElapsed_q,   lastElapsed_d;
    logic                          chkStart_q,      chkStart_d;
    logic [5:0]                    totalLat_q,      totalLat_d;
    logic [2:0]                    numPlayersLat_q, numPlayersLat_d;

    logic modeOk;
    logic tick;
    logic tickClr;

    assign modeOk = (mode_i == MODE_COMPETE);

    // Restarting the second on every state change gives each phase a full
    // first second; leaving competition mode also discards a partial second.
    assign tickClr = (state_d != state_q) || !modeOk;

    sec_tick_gen #(
        .CLK_FREQ (CLK_FREQ)
    ) u_sec_tick_gen (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (tickClr),
        .tick_o (tick)
    );

    always_comb begin
        state_d         = state_q;
        qIdx_d          = qIdx_q;
        playerIdx_d     = playerIdx_q;
        timeLeft_d      = timeLeft_q;
        scores_d        = scores_q;
        lastCorrect_d   = lastCorrect_q;
        lastTimeout_d   = lastTimeout_q;
        lastElapsed_d   = lastElapsed_q;
        totalLat_d      = totalLat_q;
        numPlayersLat_d = numPlayersLat_q;

        if (!modeOk) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_pulse_i && (total_i != '0) && (num_players_i != '0)) begin
                        state_d         = ST_READ;
                        qIdx_d          = '0;
                        playerIdx_d     = '0;
                        timeLeft_d      = READ_TIME;
                        scores_d        = '0;
                        totalLat_d      = total_i;
                        // More players than score slots cannot be tracked.
                        numPlayersLat_d = (num_players_i > 3'(MAX_P)) ? 3'(MAX_P) : num_players_i;
                    end
                end

                ST_READ: begin
                    if (tick) begin
                        if (timeLeft_q <= 5'd1) begin
                            state_d    = ST_ANSWER;
                            timeLeft_d = ANSWER_TIME;
                        end else begin
                            timeLeft_d = timeLeft_q - 5'd1;
                        end
                    end
                end

                ST_ANSWER: begin
                    // An answer arriving on the final tick still counts as an
                    // answer, so it is checked before the tick.
                    if (ans_valid_i) begin
                        state_d       = ST_RESULT;
                        lastCorrect_d = ans_correct_i;
                        lastTimeout_d = 1'b0;
                        lastElapsed_d = ANSWER_TIME - timeLeft_q;
                        if (ans_correct_i) begin
                            scores_d[playerIdx_q] = satInc(scores_q[playerIdx_q]);
                        end
                    end else if (tick) begin
                        if (timeLeft_q <= 5'd1) begin
                            state_d       = ST_RESULT;
                            lastCorrect_d = 1'b0;
                            lastTimeout_d = 1'b1;
                            lastElapsed_d = ANSWER_TIME;
                            timeLeft_d    = '0;
                        end else begin
                            timeLeft_d = timeLeft_q - 5'd1;
                        end
                    end
                end

                ST_RESULT: begin
                    if (submit_pulse_i) begin
                        state_d = ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    if (int'(qIdx_q) + 1 < int'(totalLat_q)) begin
                        state_d    = ST_READ;
                        qIdx_d     = qIdx_q + 6'd1;
                        timeLeft_d = READ_TIME;
                    end else if (int'(playerIdx_q) + 1 < int'(numPlayersLat_q)) begin
                        state_d     = ST_READ;
                        qIdx_d      = '0;
                        playerIdx_d = playerIdx_q + PIDX_W'(1);
                        timeLeft_d  = READ_TIME;
                    end else begin
                        state_d = ST_DONE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        chkStart_d = (state_d == ST_ANSWER) && (state_q != ST_ANSWER);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_IDLE;
            qIdx_q          <= '0;
            playerIdx_q     <= '0;
            timeLeft_q      <= '0;
            scores_q        <= '0;
            lastCorrect_q   <= 1'b0;
            lastTimeout_q   <= 1'b0;
            lastElapsed_q   <= '0;
            chkStart_q      <= 1'b0;
            totalLat_q      <= '0;
            numPlayersLat_q <= '0;
        end else begin
            state_q         <= state_d;
            qIdx_q          <= qIdx_d;
            playerIdx_q     <= playerIdx_d;
            timeLeft_q      <= timeLeft_d;
            scores_q        <= scores_d;
            lastCorrect_q   <= lastCorrect_d;
            lastTimeout_q   <= lastTimeout_d;
            lastElapsed_q   <= lastElapsed_d;
            chkStart_q      <= chkStart_d;
            totalLat_q      <= totalLat_d;
            numPlayersLat_q <= numPlayersLat_d;
        end
    end

    assign chk_start_o    = chkStart_q;
    assign answer_open_o  = (state_q == ST_ANSWER);
    assign round_done_o   = (state_q == ST_DONE);
    assign q_idx_o        = qIdx_q;
    assign player_idx_o   = playerIdx_q;
    assign state_o        = state_q;
    assign time_left_o    = timeLeft_q;
    assign last_correct_o = lastCorrect_q;
    assign last_timeout_o = lastTimeout_q;
    assign last_elapsed_o = lastElapsed_q;
    assign scores_flat_o  = scores_q;

endmodule

// File: tb/tb_competition_scheduler.sv
// Self-checking bench for competition_scheduler. Each question is treated
// as a transaction: the bench picks an outcome (answer at a given cycle of
// the answer window, or timeout), derives the expected verdict, elapsed
// seconds and scores with plain arithmetic, and checks the DUT at the
// question boundaries.
module tb_competition_scheduler;

    localparam int CLK_FREQ   = 10;
    localparam int READ_SEC   = 4;
    localparam int ANSWER_SEC = 20;
    localparam int SEC        = CLK_FREQ;
    localparam int S_IDLE     = 0;
    localparam int S_READ     = 1;
    localparam int S_ANSWER   = 2;
    localparam int S_RESULT   = 3;
    localparam int S_ADVANCE  = 4;
    localparam int S_DONE     = 5;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [2:0]  mode = 3'b010;
    logic [5:0]  totalIn = '0;
    logic [2:0]  numPlayersIn = '0;
    logic        startPulse = 1'b0;
    logic        submitPulse = 1'b0;
    logic        ansValid = 1'b0;
    logic        ansCorrect = 1'b0;
    logic        chkStart;
    logic        answerOpen;
    logic [5:0]  qIdx;
    logic [1:0]  playerIdx;
    logic [2:0]  state;
    logic [4:0]  timeLeft;
    logic        lastCorrect;
    logic        lastTimeout;
    logic [4:0]  lastElapsed;
    logic [23:0] scoresFlat;
    logic        roundDone;

    int testsRun = 0;
    int testsFailed = 0;
    int chkStartCount = 0;
    int expScore [4];

    always #5 clk = ~clk;

    competition_scheduler #(
        .CLK_FREQ   (CLK_FREQ),
        .READ_SEC   (READ_SEC),
        .ANSWER_SEC (ANSWER_SEC),
        .MAX_P      (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rstN),
        .mode_i         (mode),
        .total_i        (totalIn),
        .num_players_i  (numPlayersIn),
        .start_pulse_i  (startPulse),
        .submit_pulse_i (submitPulse),
        .ans_valid_i    (ansValid),
        .ans_correct_i  (ansCorrect),
        .chk_start_o    (chkStart),
        .answer_open_o  (answerOpen),
        .q_idx_o        (qIdx),
        .player_idx_o   (playerIdx),
        .state_o        (state),
        .time_left_o    (timeLeft),
        .last_correct_o (lastCorrect),
        .last_timeout_o (lastTimeout),
        .last_elapsed_o (lastElapsed),
        .scores_flat_o  (scoresFlat),
        .round_done_o   (roundDone)
    );

    // Counts checker-start pulses over the whole run.
    always @(negedge clk) begin
        if (chkStart === 1'b1) chkStartCount <= chkStartCount + 1;
    end

    // Hard stop in case the DUT wedges somewhere a bounded wait misses.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] expFlat();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*6 +: 6] = 6'(expScore[i]);
        return r;
    endfunction

    // Drive the given inputs for exactly one cycle; called at a negedge.
    task automatic applyStimulus(input bit st, input bit sb, input bit av, input bit ac);
        startPulse  = st;
        submitPulse = sb;
        ansValid    = av;
        ansCorrect  = ac;
        @(negedge clk);
        startPulse  = 1'b0;
        submitPulse = 1'b0;
        ansValid    = 1'b0;
        ansCorrect  = 1'b0;
    endtask

    task automatic waitState(input int target, input int budget, output int cycles);
        cycles = 0;
        while (int'(state) != target && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (int'(state) != target) checkOutput("wait_state", state, target);
    endtask

    task automatic checkResetState();
        checkOutput("rst_state", state, S_IDLE);
        checkOutput("rst_q_idx", qIdx, 0);
        checkOutput("rst_player_idx", playerIdx, 0);
        checkOutput("rst_time_left", timeLeft, 0);
        checkOutput("rst_scores", scoresFlat, 0);
        checkOutput("rst_last_correct", lastCorrect, 0);
        checkOutput("rst_last_timeout", lastTimeout, 0);
        checkOutput("rst_last_elapsed", lastElapsed, 0);
        checkOutput("rst_chk_start", chkStart, 0);
        checkOutput("rst_answer_open", answerOpen, 0);
        checkOutput("rst_round_done", roundDone, 0);
    endtask

    // One question. Entered on the first READ cycle. kSel: -2 random outcome,
    // -1 timeout, >=1 correct answer during cycle kSel of the answer window.
    task automatic playQuestion(input int qExp, input int pExp, input int kSel, input bit lastQ);
        int  cycles;
        int  k;
        int  sel;
        bit  corr;
        bit  injected;
        checkOutput("read_state", state, S_READ);
        checkOutput("read_time", timeLeft, READ_SEC);
        checkOutput("q_idx", qIdx, qExp);
        checkOutput("player_idx", playerIdx, pExp);
        checkOutput("scores_in_read", scoresFlat, expFlat());
        injected = 1'($urandom_range(0, 1));
        if (injected) applyStimulus(0, 1, 1, 1);
        waitState(S_ANSWER, 100, cycles);
        checkOutput("read_len", cycles, injected ? READ_SEC*SEC - 1 : READ_SEC*SEC);
        checkOutput("chk_start_first", chkStart, 1);
        checkOutput("answer_open", answerOpen, 1);
        checkOutput("answer_time", timeLeft, ANSWER_SEC);
        checkOutput("q_idx_hold", qIdx, qExp);
        if (kSel == -2) begin
            sel  = $urandom_range(0, 3);
            k    = (sel == 0) ? -1 : (sel == 1) ? ANSWER_SEC*SEC - 1 : $urandom_range(1, ANSWER_SEC*SEC - 1);
            corr = 1'($urandom_range(0, 1));
        end else begin
            k    = kSel;
            corr = 1'b1;
        end
        @(negedge clk);
        checkOutput("chk_start_second", chkStart, 0);
        if (k < 0) begin
            waitState(S_RESULT, ANSWER_SEC*SEC + 50, cycles);
            checkOutput("timeout_len", cycles + 1, ANSWER_SEC*SEC);
            checkOutput("last_timeout", lastTimeout, 1);
            checkOutput("last_correct", lastCorrect, 0);
            checkOutput("last_elapsed", lastElapsed, ANSWER_SEC);
            checkOutput("time_left_timeout", timeLeft, 0);
        end else begin
            repeat (k - 1) @(negedge clk);
            checkOutput("state_before_answer", state, S_ANSWER);
            checkOutput("time_before_answer", timeLeft, ANSWER_SEC - k/SEC);
            applyStimulus(0, 0, 1, corr);
            if (corr) expScore[pExp] = (expScore[pExp] < 63) ? expScore[pExp] + 1 : 63;
            checkOutput("answer_state", state, S_RESULT);
            checkOutput("last_timeout", lastTimeout, 0);
            checkOutput("last_correct", lastCorrect, corr);
            checkOutput("last_elapsed", lastElapsed, k/SEC);
            checkOutput("time_left_answer", timeLeft, ANSWER_SEC - k/SEC);
        end
        checkOutput("answer_closed", answerOpen, 0);
        checkOutput("scores_result", scoresFlat, expFlat());
        if ($urandom_range(0, 1) == 1) begin
            applyStimulus(0, 0, 1, 1);
            checkOutput("result_hold", state, S_RESULT);
            checkOutput("result_scores", scoresFlat, expFlat());
        end
        applyStimulus(0, 1, 0, 0);
        checkOutput("advance_state", state, S_ADVANCE);
        @(negedge clk);
        if (lastQ) begin
            checkOutput("done_state", state, S_DONE);
            checkOutput("round_done", roundDone, 1);
            checkOutput("done_scores", scoresFlat, expFlat());
        end else begin
            checkOutput("round_not_done", roundDone, 0);
        end
    endtask

    task automatic startRound(input int tot, input int np);
        totalIn      = 6'(tot);
        numPlayersIn = 3'(np);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) expScore[i] = 0;
        // Later changes must not affect the running round.
        totalIn      = 6'($urandom_range(0, 50));
        numPlayersIn = 3'($urandom_range(0, 4));
        checkOutput("scores_cleared", scoresFlat, 0);
    endtask

    task automatic playGame(input int tot, input int np, input int kFirst, input int kRest);
        startRound(tot, np);
        for (int p = 0; p < np; p++) begin
            for (int q = 0; q < tot; q++) begin
                playQuestion(q, p, (p == 0 && q == 0) ? kFirst : kRest, (p == np - 1) && (q == tot - 1));
            end
        end
    endtask

    initial begin
        int cyc;
        int chkBase;
        for (int i = 0; i < 4; i++) expScore[i] = 0;
        repeat (3) @(negedge clk);
        checkResetState();
        rstN = 1'b1;
        @(negedge clk);

        // Starts that must be ignored.
        totalIn = 6'd0; numPlayersIn = 3'd2;
        applyStimulus(1, 0, 0, 0);
        checkOutput("start_total0", state, S_IDLE);
        totalIn = 6'd3; numPlayersIn = 3'd0;
        applyStimulus(1, 0, 0, 0);
        checkOutput("start_players0", state, S_IDLE);
        totalIn = 6'd2; numPlayersIn = 3'd1; mode = 3'b000;
        applyStimulus(1, 0, 0, 0);
        checkOutput("start_wrong_mode", state, S_IDLE);
        mode = 3'b010;

        // Correct answer with 15 s left, then a timeout.
        playGame(2, 1, 5*SEC, -1);
        applyStimulus(0, 1, 1, 1);
        checkOutput("done_hold", state, S_DONE);
        checkOutput("done_frozen", scoresFlat, expFlat());

        // Three players, one question each; first answer lands on the final tick.
        chkBase = chkStartCount;
        playGame(1, 3, ANSWER_SEC*SEC - 1, -2);
        checkOutput("chk_start_pulses", chkStartCount - chkBase, 3);

        // Random rounds, each restarted from DONE.
        repeat (3) playGame($urandom_range(1, 3), $urandom_range(1, 4), -2, -2);

        // Leaving competition mode in ANSWER.
        startRound(2, 2);
        playQuestion(0, 0, 10, 1'b0);
        waitState(S_ANSWER, 100, cyc);
        mode = 3'b000;
        @(negedge clk);
        checkOutput("mode_exit_state", state, S_IDLE);
        checkOutput("mode_exit_open", answerOpen, 0);
        checkOutput("mode_exit_scores", scoresFlat, expFlat());
        checkOutput("mode_exit_last_correct", lastCorrect, 1);
        checkOutput("mode_exit_last_elapsed", lastElapsed, 1);
        mode = 3'b010;
        @(negedge clk);
        checkOutput("mode_back_idle", state, S_IDLE);

        // Asynchronous reset in the middle of READ.
        startRound(2, 1);
        playQuestion(0, 0, 10, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkResetState();
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", state, S_IDLE);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
